fp32_mul_sequencer: RTL and testbench

FP32_MUL_SEQUENCER -- requirements
Module: fp32_mul_sequencer

---
 rtl/fp32_mul_if.sv | 22 ++
 rtl/fp32_mul_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fp32_mul_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fp32_mul_if.sv
// Operand/result handshake bundle for fp32_mul_sequencer.
// The slave modport is the multiplier's view; the master modport is the producer/consumer's view.
interface fp32_mul_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/fp32_mul_sequencer.sv
// Sequential IEEE-754 single multiplier: shift-add mantissa product, fixed latency, flush-to-zero.
// FP32_MUL_ROUND_NEAREST_EN adds an RND state (round-to-nearest-even); when it is undefined the result is truncated.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// MUL   | 24 shift-add steps, one multiplier bit per cycle
// NORM  | normalise the product and select frac/guard/sticky
// RND   | round-to-nearest-even (rounding build only)
// DONE  | result held until out_ready
module fp32_mul_sequencer (
  input  logic        clk,
  input  logic        rst,
  fp32_mul_if.slave   bus
);

`ifdef FP32_MUL_ROUND_NEAREST_EN
  typedef enum logic [2:0] {IDLE, MUL, NORM, RND, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, MUL, NORM, DONE} state_t;
`endif

  state_t             state;
  logic [4:0]         cnt;
  logic [23:0]        mant_a;
  logic [47:0]        prod;
  logic signed [9:0]  exp_r;
  logic               sign_r;
  logic               is_nan;
  logic               is_inf;
  logic               is_zero;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [31:0]        result_r;
  logic               busy_r;

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = result_r;
  assign bus.busy       = busy_r;

  logic [7:0] a_exp, b_exp;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    a_exp  = bus.in_a[30:23];
    b_exp  = bus.in_b[30:23];
    a_zero = (a_exp == 8'd0);
    b_zero = (b_exp == 8'd0);
    a_inf  = (a_exp == 8'hFF) && (bus.in_a[22:0] == 23'd0);
    b_inf  = (b_exp == 8'hFF) && (bus.in_b[22:0] == 23'd0);
    a_nan  = (a_exp == 8'hFF) && (bus.in_a[22:0] != 23'd0);
    b_nan  = (b_exp == 8'hFF) && (bus.in_b[22:0] != 23'd0);
  end

  // Right-shifting accumulator: multiplier sits in the low half and is consumed LSB first.
  logic [24:0] add_sum;
  assign add_sum = {1'b0, prod[47:24]} + (prod[0] ? {1'b0, mant_a} : 25'd0);

  logic [22:0]        norm_frac;
  logic signed [9:0]  norm_exp;
  assign norm_frac = prod[47] ? prod[46:24] : prod[45:23];
  assign norm_exp  = prod[47] ? exp_r + 10'sd1 : exp_r;

  // Special classes outrank range checks; range checks use the fully adjusted exponent.
  function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                       input logic [22:0] f, input logic nan,
                                       input logic inf, input logic zero);
    if (nan)                  pack = 32'h7FC00000;
    else if (inf)             pack = {s, 8'hFF, 23'd0};
    else if (zero)            pack = {s, 31'd0};
    else if (e >= 10'sd255)   pack = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)     pack = {s, 31'd0};
    else                      pack = {s, e[7:0], f};
  endfunction

`ifdef FP32_MUL_ROUND_NEAREST_EN
  logic [22:0]        frac_r;
  logic               guard_r;
  logic               sticky_r;
  logic               norm_guard;
  logic               norm_sticky;
  logic               rnd_inc;
  logic [23:0]        rnd_sum;
  logic signed [9:0]  rnd_exp;

  assign norm_guard  = prod[47] ? prod[23] : prod[22];
  assign norm_sticky = prod[47] ? |prod[22:0] : |prod[21:0];
  assign rnd_inc     = guard_r && (sticky_r || frac_r[0]);
  assign rnd_sum     = {1'b0, frac_r} + {23'd0, rnd_inc};
  // A carry out of the fraction leaves frac at zero and bumps the exponent.
  assign rnd_exp     = rnd_sum[23] ? exp_r + 10'sd1 : exp_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      mant_a      <= 24'd0;
      prod        <= 48'd0;
      exp_r       <= 10'sd0;
      sign_r      <= 1'b0;
      is_nan      <= 1'b0;
      is_inf      <= 1'b0;
      is_zero     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= 32'd0;
      busy_r      <= 1'b0;
`ifdef FP32_MUL_ROUND_NEAREST_EN
      frac_r      <= 23'd0;
      guard_r     <= 1'b0;
      sticky_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            mant_a     <= {1'b1, bus.in_a[22:0]};
            prod       <= {24'd0, 1'b1, bus.in_b[22:0]};
            exp_r      <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;
            sign_r     <= bus.in_a[31] ^ bus.in_b[31];
            is_nan     <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
            is_inf     <= a_inf || b_inf;
            is_zero    <= a_zero || b_zero;
            cnt        <= 5'd0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= MUL;
          end
        end
        MUL: begin
          prod <= {add_sum, prod[23:1]};
          if (cnt == 5'd23) state <= NORM;
          else              cnt   <= cnt + 5'd1;
        end
        NORM: begin
`ifdef FP32_MUL_ROUND_NEAREST_EN
          frac_r   <= norm_frac;
          exp_r    <= norm_exp;
          guard_r  <= norm_guard;
          sticky_r <= norm_sticky;
          state    <= RND;
`else
          result_r    <= pack(sign_r, norm_exp, norm_frac, is_nan, is_inf, is_zero);
          out_valid_r <= 1'b1;
          state       <= DONE;
`endif
        end
`ifdef FP32_MUL_ROUND_NEAREST_EN
        RND: begin
          result_r    <= pack(sign_r, rnd_exp, rnd_sum[22:0], is_nan, is_inf, is_zero);
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_sequencer.sv
// Directed bench for fp32_mul_sequencer; expected values are hand-computed products.
// Build with FP32_MUL_ROUND_NEAREST_EN defined to check the rounding variant.
module tb_fp32_mul_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fp32_mul_if bus ();

  fp32_mul_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

`ifdef FP32_MUL_ROUND_NEAREST_EN
  localparam int          LAT     = 26;
  localparam logic [31:0] TIE_RES = 32'h3FC00002;
`else
  localparam int          LAT     = 25;
  localparam logic [31:0] TIE_RES = 32'h3FC00001;
`endif

  // Accepts one operand pair, scrambles the inputs afterwards, and waits (bounded) for out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_a = ~a; bus.in_b = 32'h12345678;
    vectors++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL accept %h*%h: busy=%b in_ready=%b, required busy=1 in_ready=0", a, b, bus.busy, bus.in_ready);
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat >= 60) begin
      miscompares++;
      $display("FAIL timeout %h*%h: out_valid=%b after %0d cycles, required 1 after %0d", a, b, bus.out_valid, lat, LAT);
    end
    res = bus.out_result;
  endtask

  task automatic ack();
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_state: out_valid=%b in_ready=%b, required 1/0", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_idle: in_ready=%b out_valid=%b busy=%b, required 1/0/0", bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_result !== 32'd0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_result=%h busy=%b, required 1/0/00000000/0",
               bus.in_ready, bus.out_valid, bus.out_result, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith();
    logic [31:0] va [5] = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'hBF800000};
    logic [31:0] vb [5] = '{32'h40000000, 32'h3FC00000, 32'h7F000000, 32'h00800000, 32'h3F800000};
    logic [31:0] ve [5] = '{32'h40400000, TIE_RES,      32'h7F800000, 32'h00000000, 32'hBF800000};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], res, lat);
      vectors++;
      if (res !== ve[i]) begin
        miscompares++;
        $display("FAIL arith %h*%h: got %h, required %h", va[i], vb[i], res, ve[i]);
      end
      vectors++;
      if (lat != LAT) begin
        miscompares++;
        $display("FAIL latency %h*%h: got %0d, required %0d", va[i], vb[i], lat, LAT);
      end
      ack();
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [5] = '{32'h7F800000, 32'h7F800000, 32'h7FC00001, 32'h80000000, 32'h00000001};
    logic [31:0] vb [5] = '{32'h00000000, 32'hC0000000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    logic [31:0] ve [5] = '{32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h80000000, 32'h00000000};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], res, lat);
      vectors++;
      if (res !== ve[i] || lat != LAT) begin
        miscompares++;
        $display("FAIL special %h*%h: got %h lat %0d, required %h lat %0d", va[i], vb[i], res, lat, ve[i], LAT);
      end
      ack();
    end
  endtask

  task automatic test_hold();
    logic [31:0] res;
    int lat;
    run_op(32'h3FC00000, 32'h40000000, res, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.out_result !== 32'h40400000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold cycle %0d: result=%h valid=%b in_ready=%b, required 40400000/1/0",
                 i, bus.out_result, bus.out_valid, bus.in_ready);
      end
    end
    ack();
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    int lat;
    bool_seen: begin end
    @(negedge clk);
    bus.in_a = 32'h3FC00000; bus.in_b = 32'h40000000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_mul: in_ready=%b out_valid=%b busy=%b, required 1/0/0", bus.in_ready, bus.out_valid, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) lat++;
    end
    vectors++;
    if (lat != 0) begin
      miscompares++;
      $display("FAIL abort_quiet: %0d cycles with out_valid/busy after abort, required 0", lat);
    end
    run_op(32'hBF800000, 32'h3F800000, res, lat);
    vectors++;
    if (res !== 32'hBF800000 || lat != LAT) begin
      miscompares++;
      $display("FAIL after_abort: got %h lat %0d, required bf800000 lat %0d", res, lat, LAT);
    end
    // Reset with a pending result and a simultaneous out_ready.
    @(negedge clk);
    rst = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'd0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_done: out_valid=%b out_result=%h busy=%b in_ready=%b, required 0/00000000/0/1",
               bus.out_valid, bus.out_result, bus.busy, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    run_op(32'h40400000, 32'h40400000, res, lat);
    vectors++;
    if (res !== 32'h41100000) begin
      miscompares++;
      $display("FAIL b2b_first: got %h, required 41100000", res);
    end
    ack();
    run_op(32'h3F000000, 32'h3F000000, res, lat);
    vectors++;
    if (res !== 32'h3E800000 || lat != LAT) begin
      miscompares++;
      $display("FAIL b2b_second: got %h lat %0d, required 3e800000 lat %0d", res, lat, LAT);
    end
    ack();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_a = 32'd0; bus.in_b = 32'd0; bus.out_ready = 1'b0;
    test_reset();
    test_arith();
    test_specials();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
